imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning byte-address width of the shared instruction store (1024 bytes).
REQ-002 SHALL have parameter STARVE_MAX, default 3, meaning the number of consecutive denied loader cycles before the loader is forced a grant.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port fetch_req, input, 1, fetch stage requests an instruction word.
REQ-006 SHALL have port fetch_addr, input, 32, byte address (PC) of the requested word.
REQ-007 SHALL have port fetch_gnt, output, 1, fetch request accepted this cycle.
REQ-008 SHALL have port fetch_valid, output, 1, fetch_instr valid this cycle.
REQ-009 SHALL have port fetch_instr, output, 32, returned instruction word, big-endian byte order.
REQ-010 SHALL have port fetch_err, output, 1, qualifies fetch_valid: misaligned or out-of-range address.
REQ-011 SHALL have port load_req, input, 1, program loader requests a word write.
REQ-012 SHALL have port load_addr, input, 32, byte address of the word write.
REQ-013 SHALL have port load_data, input, 32, word to write, big-endian.
REQ-014 SHALL have port load_ack, output, 1, loader write accepted this cycle.
REQ-015 SHALL have port load_err, output, 1, qualifies load_ack: write discarded (misaligned or out of range).
REQ-016 SHALL have ports mem_en (output, 1), mem_we (output, 1), mem_addr (output, ADDR_W), mem_wdata (output, 32) and mem_rdata (input, 32); together these form the single-port memory interface, and mem_rdata is valid one cycle after mem_en with mem_we=0.

Function
REQ-017 SHALL grant at most one requester per cycle; fetch_gnt and load_ack are combinational in the request cycle.
REQ-018 SHALL give fetch priority unless starve_cnt equals STARVE_MAX and load_req is high, in which case the loader wins.
REQ-019 SHALL, for starve_cnt, increment it (saturating at STARVE_MAX) in each cycle where load_req is high and not acked, and clear it to 0 on load_ack or when load_req is low.
REQ-020 SHALL, on a granted valid fetch, drive mem_en=1, mem_we=0 and mem_addr=fetch_addr[ADDR_W-1:0]; fetch_valid=1 and fetch_instr=mem_rdata exactly one cycle later.
REQ-021 SHALL, on a granted valid load, drive mem_en=1, mem_we=1, mem_addr=load_addr[ADDR_W-1:0] and mem_wdata=load_data in the same cycle; load_ack=1 and load_err=0.
REQ-022 SHALL treat a fetch as invalid if fetch_addr[1:0]!=0 or fetch_addr[31:ADDR_W]!=0; such a fetch is still granted, mem_en stays 0, and one cycle later fetch_valid=1, fetch_err=1 and fetch_instr=32'h0000_0000 (NOP).
REQ-023 SHALL treat a load with the same invalid-address condition as discarded: load_ack=1, load_err=1 and mem_en=0.
REQ-024 SHALL deliver newly written data to a fetch of the same address granted in the next cycle; there is no internal read-data caching.
REQ-025 SHALL drive mem_en=0, fetch_gnt=0 and load_ack=0 when neither requester is active; outputs hold no stale grant.
REQ-026 SHALL drive fetch_valid low in any cycle not following a fetch grant; fetch_instr holds its last value.

Reset
REQ-027 SHALL, while reset=1, force fetch_gnt, load_ack, load_err, mem_en, mem_we, fetch_valid and fetch_err to 0, clear starve_cnt and fetch_instr to 0, and drive mem_addr and mem_wdata to 0.
REQ-028 SHALL ensure that reset asserted in the cycle after a fetch grant suppresses that fetch_valid; no response is produced.

Structure
REQ-029 SHALL place the NOP constant (32'h0000_0000) and the default ADDR_W in a shared package, mips_pkg.
REQ-030 SHALL implement the address-check logic as one sub-module, imem_addr_chk, instanced twice (fetch and load); the arbitration FSM and counter remain in imem_arbiter.

Verification
REQ-031 SHALL cover: fetch_req=1, addr=0x4, mem_rdata=0x2108_0008 -> next cycle fetch_valid=1, instr=0x2108_0008, err=0.
REQ-032 SHALL cover: fetch and load held high continuously -> load_ack every 4th cycle (STARVE_MAX=3) and fetch_gnt in the other 3 cycles.
REQ-033 SHALL cover: load addr=0x1A0, data=0x0128_5020, then fetch 0x1A0 the next cycle -> fetch_instr=0x0128_5020.
REQ-034 SHALL cover: fetch_addr=0x6 and separately 0x400 -> mem_en=0, then fetch_valid=1, err=1, instr=0; load to 0x401 -> load_ack=1, load_err=1, no write.
REQ-035 SHALL cover: a fetch grant followed by reset the next cycle -> fetch_valid=0, and starve_cnt=0 after reset.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and types for the instruction-memory front end.
package mips_pkg;

    localparam int unsigned IMEM_ADDR_W = 10;
    localparam int unsigned WORD_W      = 32;

    localparam logic [WORD_W-1:0] NOP = 32'h0000_0000;

    // Response pending for the cycle after a fetch grant
    typedef struct packed {
        logic valid;
        logic err;
    } imem_rsp_t;

endpackage

// File: rtl/imem_addr_chk.sv
// Flags an address as usable: word aligned and inside the instruction store.
module imem_addr_chk
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W = IMEM_ADDR_W
) (
    input  logic [WORD_W-1:0] addr,
    output logic              addr_ok_c
);

    // Aligned low bits and no bits set above the store's byte range
    always_comb begin
        addr_ok_c = (addr[1:0] == 2'b00) && ((addr >> ADDR_W) == '0);
    end

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates a fetch port and a program-loader port onto one single-port
// instruction store. Fetch has priority; a loader starved for STARVE_MAX
// consecutive cycles is forced through.
module imem_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W     = IMEM_ADDR_W,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_valid,
    output logic [31:0]       fetch_instr,
    output logic              fetch_err,

    input  logic              load_req,
    input  logic [31:0]       load_addr,
    input  logic [31:0]       load_data,
    output logic              load_ack,
    output logic              load_err,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic             fetch_ok_c;
    logic             load_ok_c;
    logic             starve_at_max_c;
    logic [CNT_W-1:0] starve_cnt_q;
    imem_rsp_t        rsp_q;
    logic [31:0]      instr_hold_q;

    imem_addr_chk #(.ADDR_W(ADDR_W)) u_fetch_chk (
        .addr      (fetch_addr),
        .addr_ok_c (fetch_ok_c)
    );

    imem_addr_chk #(.ADDR_W(ADDR_W)) u_load_chk (
        .addr      (load_addr),
        .addr_ok_c (load_ok_c)
    );

    assign starve_at_max_c = (starve_cnt_q == CNT_W'(STARVE_MAX));

    // Same-cycle grant and memory command; bad addresses are granted but never touch memory
    always_comb begin
        fetch_gnt = 1'b0;
        load_ack  = 1'b0;
        load_err  = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!reset) begin
            if (load_req && (!fetch_req || starve_at_max_c)) begin
                load_ack = 1'b1;
                load_err = !load_ok_c;
                if (load_ok_c) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = load_addr[ADDR_W-1:0];
                    mem_wdata = load_data;
                end
            end else if (fetch_req) begin
                fetch_gnt = 1'b1;
                if (fetch_ok_c) begin
                    mem_en   = 1'b1;
                    mem_addr = fetch_addr[ADDR_W-1:0];
                end
            end
        end
    end

    // Fetch response: read data passes straight through in the cycle after the grant
    always_comb begin
        fetch_valid = 1'b0;
        fetch_err   = 1'b0;
        fetch_instr = instr_hold_q;
        if (reset) begin
            fetch_instr = NOP;
        end else if (rsp_q.valid) begin
            fetch_valid = 1'b1;
            fetch_err   = rsp_q.err;
            fetch_instr = rsp_q.err ? NOP : mem_rdata;
        end
    end

    // Starvation counter, pending response and held instruction word
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q <= '0;
            rsp_q        <= '0;
            instr_hold_q <= NOP;
        end else begin
            rsp_q.valid  <= fetch_gnt;
            rsp_q.err    <= fetch_gnt && !fetch_ok_c;
            instr_hold_q <= fetch_instr;
            if (load_req && !load_ack) begin
                if (!starve_at_max_c) begin
                    starve_cnt_q <= starve_cnt_q + CNT_W'(1);
                end
            end else begin
                starve_cnt_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter with a behavioural memory and reference model.
module tb_imem_arbiter;

    localparam int STARVE_MAX = 3;
    localparam int OBS_W      = 81;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req, load_req;
    logic [31:0] fetch_addr, load_addr, load_data;
    logic        fetch_gnt, fetch_valid, fetch_err, load_ack, load_err;
    logic [31:0] fetch_instr;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int checks = 0;
    int failures = 0;

    imem_arbiter #(.ADDR_W(10), .STARVE_MAX(STARVE_MAX)) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_gnt   (fetch_gnt),
        .fetch_valid (fetch_valid),
        .fetch_instr (fetch_instr),
        .fetch_err   (fetch_err),
        .load_req    (load_req),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .load_ack    (load_ack),
        .load_err    (load_err),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port store seen by the DUT
    logic [31:0] ram [0:255];
    always @(posedge clk) begin
        if (mem_en && mem_we)  ram[mem_addr[9:2]] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= ram[mem_addr[9:2]];
    end

    // Reference model state
    logic [31:0] ref_mem [0:255];
    int          m_starve;
    bit          m_pend, m_pend_err;
    logic [31:0] m_pend_addr, m_instr;
    logic        e_gnt, e_ack, e_lerr, e_en, e_we, e_valid, e_ferr;
    logic [9:0]  e_addr;
    logic [31:0] e_wdata, e_instr;
    logic [OBS_W-1:0] exp_vec;

    function automatic bit addr_ok(logic [31:0] a);
        return (a % 4 == 0) && (a < 32'd1024);
    endfunction

    function automatic logic [OBS_W-1:0] obs_vec();
        return {fetch_gnt, load_ack, load_err, mem_en, mem_we, mem_addr, mem_wdata,
                fetch_valid, fetch_err, fetch_instr};
    endfunction

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return ($urandom | 32'h0000_0400) & 32'hFFFF_FFFC;
        if (r == 1) return (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
        return 32'($urandom_range(0, 255)) << 2;
    endfunction

    // Expected outputs for the current cycle from the arbitration rules
    task automatic model_eval();
        bit lwin;
        e_gnt = 0; e_ack = 0; e_lerr = 0; e_en = 0; e_we = 0;
        e_addr = '0; e_wdata = '0; e_valid = 0; e_ferr = 0; e_instr = '0;
        if (!reset) begin
            lwin = load_req && (!fetch_req || m_starve == STARVE_MAX);
            if (lwin) begin
                e_ack  = 1;
                e_lerr = !addr_ok(load_addr);
                if (addr_ok(load_addr)) begin
                    e_en = 1; e_we = 1; e_addr = load_addr[9:0]; e_wdata = load_data;
                end
            end else if (fetch_req) begin
                e_gnt = 1;
                if (addr_ok(fetch_addr)) begin
                    e_en = 1; e_addr = fetch_addr[9:0];
                end
            end
            e_valid = m_pend;
            e_ferr  = m_pend && m_pend_err;
            e_instr = !m_pend ? m_instr : (m_pend_err ? 32'h0 : ref_mem[m_pend_addr[9:2]]);
        end
        exp_vec = {e_gnt, e_ack, e_lerr, e_en, e_we, e_addr, e_wdata, e_valid, e_ferr, e_instr};
    endtask

    // Advance model state across the clock edge
    task automatic model_commit();
        if (reset) begin
            m_starve = 0; m_pend = 0; m_pend_err = 0; m_instr = '0;
        end else begin
            m_instr     = e_instr;
            m_pend      = e_gnt;
            m_pend_err  = !addr_ok(fetch_addr);
            m_pend_addr = fetch_addr;
            if (e_ack && !e_lerr) ref_mem[load_addr[9:2]] = load_data;
            if (load_req && !e_ack) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
            else m_starve = 0;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(bit fr, logic [31:0] fa, bit lr, logic [31:0] la, logic [31:0] ld);
        fetch_req = fr; fetch_addr = fa; load_req = lr; load_addr = la; load_data = ld;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 32'h4, 1'b1, 32'h8, $urandom);
            settle();
            checks++;
            if (obs_vec() !== '0) begin
                failures++;
                $display("FAIL reset_outputs cyc=%0d got=%h want=0", i, obs_vec());
            end
            advance();
        end
        reset = 1'b0;
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_idle();
        for (int i = 0; i < 2; i++) begin
            set_in(1'b0, $urandom, 1'b0, $urandom, $urandom);
            settle();
            checks++;
            if ({fetch_gnt, load_ack, mem_en, fetch_valid} !== 4'b0000) begin
                failures++;
                $display("FAIL idle gnt/ack/en/valid got=%b want=0000",
                         {fetch_gnt, load_ack, mem_en, fetch_valid});
            end
            advance();
        end
    endtask

    task automatic test_fetch_basic();
        set_in(1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
        settle();
        checks++;
        if ({fetch_gnt, mem_en, mem_we, mem_addr} !== {3'b110, 10'h004}) begin
            failures++;
            $display("FAIL fetch_cmd got=%b/%b/%b/%h want=1/1/0/004", fetch_gnt, mem_en, mem_we, mem_addr);
        end
        advance();
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        settle();
        checks++;
        if ({fetch_valid, fetch_err, fetch_instr} !== {2'b10, 32'h2108_0008}) begin
            failures++;
            $display("FAIL fetch_rsp got=%b/%b/%h want=1/0/21080008", fetch_valid, fetch_err, fetch_instr);
        end
        advance();
        settle();
        checks++;
        if ({fetch_valid, fetch_instr} !== {1'b0, 32'h2108_0008}) begin
            failures++;
            $display("FAIL fetch_hold got=%b/%h want=0/21080008", fetch_valid, fetch_instr);
        end
        advance();
    endtask

    task automatic test_starvation();
        for (int i = 0; i < 12; i++) begin
            set_in(1'b1, 32'($urandom_range(0, 255)) << 2, 1'b1, 32'h3F0, $urandom);
            settle();
            checks++;
            if ({load_ack, fetch_gnt} !== ((i % 4 == 3) ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL starve_pattern cyc=%0d ack/gnt got=%b%b want=%0s",
                         i, load_ack, fetch_gnt, (i % 4 == 3) ? "10" : "01");
            end
            advance();
        end
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        settle();
        advance();
    endtask

    task automatic test_write_then_fetch();
        set_in(1'b0, 32'h0, 1'b1, 32'h1A0, 32'h0128_5020);
        settle();
        checks++;
        if ({load_ack, load_err, mem_en, mem_we, mem_addr, mem_wdata} !== {4'b1011, 10'h1A0, 32'h0128_5020}) begin
            failures++;
            $display("FAIL load_cmd got=%b%b%b%b/%h/%h want=1011/1a0/01285020",
                     load_ack, load_err, mem_en, mem_we, mem_addr, mem_wdata);
        end
        advance();
        set_in(1'b1, 32'h1A0, 1'b0, 32'h0, 32'h0);
        settle();
        advance();
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        settle();
        checks++;
        if ({fetch_valid, fetch_err, fetch_instr} !== {2'b10, 32'h0128_5020}) begin
            failures++;
            $display("FAIL write_fetch got=%b/%b/%h want=1/0/01285020", fetch_valid, fetch_err, fetch_instr);
        end
        advance();
    endtask

    task automatic test_bad_addr();
        logic [31:0] bad [2];
        logic [31:0] w0;
        bad[0] = 32'h6; bad[1] = 32'h400;
        for (int k = 0; k < 2; k++) begin
            set_in(1'b1, bad[k], 1'b0, 32'h0, 32'h0);
            settle();
            checks++;
            if ({fetch_gnt, mem_en} !== 2'b10) begin
                failures++;
                $display("FAIL bad_fetch_cmd addr=%h gnt/en got=%b%b want=10", bad[k], fetch_gnt, mem_en);
            end
            advance();
            set_in(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
            settle();
            checks++;
            if ({fetch_valid, fetch_err, fetch_instr} !== {2'b11, 32'h0}) begin
                failures++;
                $display("FAIL bad_fetch_rsp addr=%h got=%b/%b/%h want=1/1/00000000",
                         bad[k], fetch_valid, fetch_err, fetch_instr);
            end
            advance();
        end
        w0 = ref_mem[0];
        set_in(1'b0, 32'h0, 1'b1, 32'h401, ~w0);
        settle();
        checks++;
        if ({load_ack, load_err, mem_en} !== 3'b110) begin
            failures++;
            $display("FAIL bad_load ack/err/en got=%b%b%b want=110", load_ack, load_err, mem_en);
        end
        advance();
        set_in(1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        settle();
        advance();
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        settle();
        checks++;
        if ({fetch_valid, fetch_instr} !== {1'b1, w0}) begin
            failures++;
            $display("FAIL bad_load_nowrite got=%b/%h want=1/%h", fetch_valid, fetch_instr, w0);
        end
        advance();
    endtask

    task automatic test_reset_after_grant();
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 32'h8, 1'b1, 32'h10, $urandom);
            settle();
            advance();
        end
        reset = 1'b1;
        set_in(1'b0, 32'h0, 1'b1, 32'h10, $urandom);
        settle();
        checks++;
        if ({fetch_valid, fetch_err, load_ack, fetch_instr} !== {3'b000, 32'h0}) begin
            failures++;
            $display("FAIL reset_after_grant got=%b/%b/%b/%h want=0/0/0/00000000",
                     fetch_valid, fetch_err, load_ack, fetch_instr);
        end
        advance();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 32'hC, 1'b1, 32'h14, $urandom);
            settle();
            checks++;
            if (load_ack !== (i == 3)) begin
                failures++;
                $display("FAIL starve_cleared cyc=%0d ack got=%b want=%0d", i, load_ack, (i == 3));
            end
            advance();
        end
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 39) == 0);
            set_in($urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 2) != 0,
                   rand_addr(), $urandom);
            settle();
            checks++;
            if (obs_vec() !== exp_vec) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec);
            end
            advance();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        m_starve = 0; m_pend = 0; m_pend_err = 0; m_pend_addr = '0; m_instr = '0;
        for (int i = 0; i < 256; i++) begin
            logic [31:0] v;
            v = (i == 1) ? 32'h2108_0008 : $urandom;
            ref_mem[i] = v;
            ram[i] <= v;
        end
        test_reset();
        test_idle();
        test_fetch_basic();
        test_starvation();
        test_write_then_fetch();
        test_bad_addr();
        test_reset_after_grant();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
